tft_bus_if: RTL
===============

# tft_bus_if

Consumer end of the TFT pixel write path. Takes pixel-write requests (24-bit address, 16-bit RGB565 data) from the high-speed request/ready interface fed by the TFT write FIFO. Drives an 8080-style 16-bit parallel panel bus, issuing column/page/memory-write command sequences only when the target pixel is not the next pixel the panel's auto-increment cursor would write.

## Interface
Parameters:
- WIDTH, 320, panel columns; x in [0, WIDTH-1]
- HEIGHT, 240, panel rows; y in [0, HEIGHT-1]
- WR_LOW, 2, clocks tft_wr_n is held low per bus word (>=1)
- WR_HIGH, 2, clocks tft_wr_n is held high per bus word (>=1)

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous, active-low reset
- req  in  1  request valid from FIFO side
- rdy  out  1  block ready; transfer on rising clk when req & rdy
- addr  in  24  pixel address: addr[23:12] = y, addr[11:0] = x
- data  in  16  RGB565 pixel
- drop  out  1  one-cycle pulse when an out-of-range request is discarded
- tft_cs_n  out  1  panel chip select
- tft_rs  out  1  0 = command word, 1 = parameter/pixel word
- tft_wr_n  out  1  write strobe; panel latches on rising edge
- tft_rd_n  out  1  tied high
- tft_data  out  16  panel data bus

## Operation
- States: IDLE, LOAD, STROBE_LO, STROBE_HI.
- rdy = (state == IDLE), combinational decode of state.
- In IDLE, an accept edge (req & rdy) latches addr/data.
- Out-of-range request (x >= WIDTH or y >= HEIGHT):
  - drop = 1 for the following cycle.
  - Stays in IDLE; no bus activity; cursor unchanged.
- In range, builds a word sequence:
  - Short sequence (1 word): pixel only, used when cursor_valid and (x,y) == predicted cursor.
  - Long sequence (12 words): 0x2A, x[15:8], x[7:0], (WIDTH-1)[15:8], (WIDTH-1)[7:0], 0x2B, y[15:8], y[7:0], (HEIGHT-1)[15:8], (HEIGHT-1)[7:0], 0x2C, pixel. x and y are zero-extended to 16 bits.
- Word encoding:
  - Command words: rs = 0, value on tft_data[7:0], tft_data[15:8] = 0.
  - Parameter words: rs = 1, same byte placement.
  - Pixel word: rs = 1, full 16-bit data.
- Per word: LOAD drives rs/data → STROBE_LO (WR_LOW clocks, wr_n = 0) → STROBE_HI (WR_HIGH clocks, wr_n = 1).
  - rs and data are held stable from LOAD through the end of STROBE_HI.
  - After the last STROBE_HI, go to the next word's LOAD, or to IDLE after the final word.
- Cursor update, after the pixel word completes:
  - predicted = (x+1, y).
  - If x+1 == WIDTH: predicted = (0, y+1).
  - If also y+1 == HEIGHT: predicted = (0, 0).
  - cursor_valid = 1.
- The 12-bit coordinate compare uses the full fields; upper bits beyond the panel range are caught by the range check.

## Timing
- Reset values: rdy = 1, drop = 0, tft_cs_n = 1, tft_rs = 1, tft_wr_n = 1, tft_rd_n = 1, tft_data = 0, cursor_valid = 0.
- Asserting n_reset mid-sequence forces the above immediately (asynchronous). The partial panel sequence is abandoned, and the next accepted pixel always uses the long sequence.
- Accept at edge T: tft_cs_n goes low and the first word is on the bus from T+1. tft_wr_n falls at T+2.
- Word period = 1 + WR_LOW + WR_HIGH clocks (5 at defaults).
- tft_cs_n stays low for the whole sequence and returns high on re-entering IDLE.
- Short sequence: rdy returns high 1 + WR_LOW + WR_HIGH clocks after accept (5 at defaults), giving one pixel per 6 clocks with req held high.
- Long sequence: rdy returns high 12*(1+WR_LOW+WR_HIGH) clocks after accept (60 at defaults).
- addr/data are sampled only at the accept edge; later changes are ignored. req while busy is ignored; the request is held by the FIFO.
- Accepted writes are never lost except by reset or drop.

## Configuration
- TFT_CURSOR_SKIP_EN defined:
  - The contiguous-pixel short sequence is enabled as described.
- TFT_CURSOR_SKIP_EN undefined:
  - Every in-range pixel uses the 12-word long sequence.
  - cursor_valid and predicted-cursor logic are removed.
  - Bus timing and all other behaviour are unchanged.

## Test plan
- Reset, then check outputs. Accept (x=5, y=7, data=0xF800) → 12 words in order: 0x2A/00/05/01/3F, 0x2B/00/07/00/EF, 0x2C (rs = 0 on the three commands), then pixel 0xF800 with rs = 1. rdy goes high 60 clocks after accept.
- With the macro defined, follow with (6, 7, 0x07E0) → single pixel word 0x07E0, no commands. rdy goes high 5 clocks after accept.
- Write (319, 10), then (0, 11) → second write is short. Write (319, 239), then (0, 0) → second write is short (full-frame wrap).
- Write (100, 50) → addr 0x032064 → long sequence. Write (101, 60) → long sequence (non-contiguous row).
- addr with x=320 or y=240 → drop pulses one cycle, no tft_cs_n activity, rdy stays 1. The next contiguous pixel is still short.
- Pulse n_reset during word 4 of a long sequence → bus returns to idle levels immediately. The next pixel, even if at the predicted cursor, uses the long sequence.

Source files
------------

// File: rtl/tft_bus_if.sv
// 8080-style 16-bit panel writer: takes pixel requests and emits column/page/memory-write
// sequences, skipping the address commands when TFT_CURSOR_SKIP_EN is defined and the pixel follows the cursor.
module tft_bus_if #(
   parameter int WIDTH   = 320,
   parameter int HEIGHT  = 240,
   parameter int WR_LOW  = 2,
   parameter int WR_HIGH = 2
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        req,
   output logic        rdy,
   input  logic [23:0] addr,
   input  logic [15:0] data,
   output logic        drop,
   output logic        tft_cs_n,
   output logic        tft_rs,
   output logic        tft_wr_n,
   output logic        tft_rd_n,
   output logic [15:0] tft_data
);

   localparam logic [1:0]  IDLE      = 2'd0;
   localparam logic [1:0]  LOAD      = 2'd1;
   localparam logic [1:0]  STROBE_LO = 2'd2;
   localparam logic [1:0]  STROBE_HI = 2'd3;
   localparam logic [11:0] X_LIM     = 12'(WIDTH);
   localparam logic [11:0] Y_LIM     = 12'(HEIGHT);
   localparam logic [15:0] X_MAX     = 16'(WIDTH - 1);
   localparam logic [15:0] Y_MAX     = 16'(HEIGHT - 1);
   localparam logic [3:0]  LAST      = 4'd11;
   localparam logic [7:0]  LO_CNT    = 8'(WR_LOW - 1);
   localparam logic [7:0]  HI_CNT    = 8'(WR_HIGH - 1);

   logic [1:0]  state;
   logic [3:0]  idx;
   logic [7:0]  cnt;
   logic [11:0] x;
   logic [11:0] y;
   logic [15:0] pix;
   logic        in_range;
   logic        short_hit;
   logic [3:0]  start_idx;
   logic        seq_done;

   // Word idx of the long sequence as {rs, bus value}; idx 11 is always the pixel.
   function automatic logic [16:0] word_of(input logic [3:0] i, input logic [11:0] wx,
                                           input logic [11:0] wy, input logic [15:0] p);
      logic [15:0] x16;
      logic [15:0] y16;
      x16 = {4'h0, wx};
      y16 = {4'h0, wy};
      case (i)
         4'd0:    word_of = {1'b0, 16'h002A};
         4'd1:    word_of = {1'b1, 8'h00, x16[15:8]};
         4'd2:    word_of = {1'b1, 8'h00, x16[7:0]};
         4'd3:    word_of = {1'b1, 8'h00, X_MAX[15:8]};
         4'd4:    word_of = {1'b1, 8'h00, X_MAX[7:0]};
         4'd5:    word_of = {1'b0, 16'h002B};
         4'd6:    word_of = {1'b1, 8'h00, y16[15:8]};
         4'd7:    word_of = {1'b1, 8'h00, y16[7:0]};
         4'd8:    word_of = {1'b1, 8'h00, Y_MAX[15:8]};
         4'd9:    word_of = {1'b1, 8'h00, Y_MAX[7:0]};
         4'd10:   word_of = {1'b0, 16'h002C};
         default: word_of = {1'b1, p};
      endcase
   endfunction

   assign rdy      = (state == IDLE);
   assign tft_rd_n = 1'b1;

   // Request decode and end-of-sequence detection.
   always_comb begin
      in_range  = (addr[11:0] < X_LIM) && (addr[23:12] < Y_LIM);
      start_idx = short_hit ? LAST : 4'd0;
      seq_done  = (state == STROBE_HI) && (cnt == 8'd0) && (idx == LAST);
   end

`ifdef TFT_CURSOR_SKIP_EN
   logic        cursor_valid;
   logic [11:0] cur_x;
   logic [11:0] cur_y;

   assign short_hit = cursor_valid && (addr[11:0] == cur_x) && (addr[23:12] == cur_y);

   // Predicted auto-increment position after each completed pixel, wrapping row then frame.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cursor_valid <= 1'b0;
         cur_x        <= 12'd0;
         cur_y        <= 12'd0;
      end else if (seq_done) begin
         cursor_valid <= 1'b1;
         if ((x + 12'd1) == X_LIM) begin
            cur_x <= 12'd0;
            cur_y <= ((y + 12'd1) == Y_LIM) ? 12'd0 : (y + 12'd1);
         end else begin
            cur_x <= x + 12'd1;
            cur_y <= y;
         end
      end
   end
`else
   assign short_hit = 1'b0;
`endif

   // Sequencer: latches a request, then steps LOAD -> STROBE_LO -> STROBE_HI per bus word.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state    <= IDLE;
         idx      <= 4'd0;
         cnt      <= 8'd0;
         x        <= 12'd0;
         y        <= 12'd0;
         pix      <= 16'd0;
         drop     <= 1'b0;
         tft_cs_n <= 1'b1;
         tft_rs   <= 1'b1;
         tft_wr_n <= 1'b1;
         tft_data <= 16'd0;
      end else begin
         drop <= 1'b0;
         case (state)
            IDLE: begin
               if (req && in_range) begin
                  x                  <= addr[11:0];
                  y                  <= addr[23:12];
                  pix                <= data;
                  idx                <= start_idx;
                  {tft_rs, tft_data} <= word_of(start_idx, addr[11:0], addr[23:12], data);
                  tft_cs_n           <= 1'b0;
                  state              <= LOAD;
               end else if (req) begin
                  drop <= 1'b1;
               end
            end
            LOAD: begin
               tft_wr_n <= 1'b0;
               cnt      <= LO_CNT;
               state    <= STROBE_LO;
            end
            STROBE_LO: begin
               if (cnt == 8'd0) begin
                  tft_wr_n <= 1'b1;
                  cnt      <= HI_CNT;
                  state    <= STROBE_HI;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            STROBE_HI: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else if (idx == LAST) begin
                  tft_cs_n <= 1'b1;
                  state    <= IDLE;
               end else begin
                  idx                <= idx + 4'd1;
                  {tft_rs, tft_data} <= word_of(idx + 4'd1, x, y, pix);
                  state              <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
